// File: rtl/ft_recovery_ctrl_if.sv
// Control/status bundle between the lockstep error comparator, the recovery
// sequencer and the core reset / checkpoint-restore logic.
interface ft_recovery_ctrl_if #(
  parameter int unsigned MAX_RETRIES = 2,
  parameter int unsigned CNT_W       = 8
);
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic             enable_i;
  logic             error_i;
  logic             force_error_i;
  logic             recovery_done_i;
  logic             clear_fault_i;
  logic             reset_cores_o;
  logic             recover_o;
  logic             recovering_o;
  logic             fault_o;
  logic [RW-1:0]    retry_count_o;
  logic [CNT_W-1:0] error_count_o;

  modport master (
    output enable_i, error_i, force_error_i, recovery_done_i, clear_fault_i,
    input  reset_cores_o, recover_o, recovering_o, fault_o,
           retry_count_o, error_count_o
  );

  modport slave (
    input  enable_i, error_i, force_error_i, recovery_done_i, clear_fault_i,
    output reset_cores_o, recover_o, recovering_o, fault_o,
           retry_count_o, error_count_o
  );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Lockstep fault-recovery sequencer: reset -> recover -> wait-for-done with a
// completion watchdog, bounded retries, sticky permanent fault, saturating error count.
module ft_recovery_ctrl #(
  parameter int unsigned RESET_CYCLES   = 1,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter int unsigned CNT_W          = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  ft_recovery_ctrl_if.slave bus
);
  localparam int unsigned RW     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int unsigned PH_MAX = (RESET_CYCLES > RECOVER_CYCLES)
                                   ? ((RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES)
                                   : ((RECOVER_CYCLES > TIMEOUT_CYCLES) ? RECOVER_CYCLES : TIMEOUT_CYCLES);
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]  REC_LAST = PH_W'(RECOVER_CYCLES - 1);
  localparam logic [PH_W-1:0]  TO_LAST  = PH_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [RW-1:0]    RT_MAX   = RW'(MAX_RETRIES);
  localparam logic [RW-1:0]    RT_ONE   = RW'(1);
  localparam logic [CNT_W-1:0] EC_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RECOVER,
    ST_WAIT_DONE,
    ST_DONE,
    ST_FAULT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PH_W-1:0]  r_phase, w_phase_nxt;
  logic [RW-1:0]    r_retry, w_retry_nxt;
  logic [CNT_W-1:0] r_errcnt, w_errcnt_nxt;
  logic             r_reset_cores, r_recover, r_recovering, r_fault;
  logic             w_err;

  assign w_err = bus.error_i | bus.force_error_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_retry_nxt  = r_retry;
    w_errcnt_nxt = r_errcnt;
    if (bus.enable_i) begin
      case (r_state)
        ST_IDLE: if (w_err) begin
          w_state_nxt = ST_RESET;
          w_phase_nxt = '0;
          w_retry_nxt = '0;
          if (r_errcnt != '1) w_errcnt_nxt = r_errcnt + EC_ONE;
        end
        ST_RESET: if (r_phase == RST_LAST) begin
          w_state_nxt = ST_RECOVER;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PH_ONE;
        end
        ST_RECOVER: if (r_phase == REC_LAST) begin
          w_state_nxt = ST_WAIT_DONE;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PH_ONE;
        end
        // done is checked before the watchdog so it wins a same-cycle tie
        ST_WAIT_DONE: if (bus.recovery_done_i) begin
          w_state_nxt = ST_DONE;
          w_phase_nxt = '0;
        end else if (r_phase == TO_LAST) begin
          w_phase_nxt = '0;
          if (r_retry < RT_MAX) begin
            w_retry_nxt = r_retry + RT_ONE;
            w_state_nxt = ST_RESET;
          end else begin
            w_state_nxt = ST_FAULT;
          end
        end else begin
          w_phase_nxt = r_phase + PH_ONE;
        end
        ST_DONE:  w_state_nxt = ST_IDLE;
        ST_FAULT: if (bus.clear_fault_i) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they track r_state exactly.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_phase       <= '0;
      r_retry       <= '0;
      r_errcnt      <= '0;
      r_reset_cores <= 1'b0;
      r_recover     <= 1'b0;
      r_recovering  <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_retry       <= w_retry_nxt;
      r_errcnt      <= w_errcnt_nxt;
      r_reset_cores <= (w_state_nxt == ST_RESET);
      r_recover     <= (w_state_nxt == ST_RECOVER);
      r_recovering  <= (w_state_nxt == ST_RECOVER) || (w_state_nxt == ST_WAIT_DONE);
      r_fault       <= (w_state_nxt == ST_FAULT);
    end
  end

  assign bus.reset_cores_o = r_reset_cores;
  assign bus.recover_o     = r_recover;
  assign bus.recovering_o  = r_recovering;
  assign bus.fault_o       = r_fault;
  assign bus.retry_count_o = r_retry;
  assign bus.error_count_o = r_errcnt;
endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Scoreboard bench for ft_recovery_ctrl: two instances (CNT_W=8 and CNT_W=2) share
// one stimulus; per-cycle expected outputs are queued by the driver and checked after each falling edge.
module tb_ft_recovery_ctrl;
  typedef enum int {E_IDLE, E_RST, E_REC, E_WAIT, E_DONE, E_FLT} est_t;
  typedef struct {
    logic [13:0] vm;
    logic [7:0]  vs;
    int          cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i, en, err, force_e, done, clear;
  logic [1:0] exp_rt;
  logic [7:0] exp_ec;
  int n_cmp = 0;
  int n_err = 0;
  int ncyc  = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk_i = ~clk_i;

  ft_recovery_ctrl_if #(.MAX_RETRIES(2), .CNT_W(8)) bus_m ();
  ft_recovery_ctrl_if #(.MAX_RETRIES(2), .CNT_W(2)) bus_s ();

  assign bus_m.enable_i        = en;
  assign bus_m.error_i         = err;
  assign bus_m.force_error_i   = force_e;
  assign bus_m.recovery_done_i = done;
  assign bus_m.clear_fault_i   = clear;
  assign bus_s.enable_i        = en;
  assign bus_s.error_i         = err;
  assign bus_s.force_error_i   = force_e;
  assign bus_s.recovery_done_i = done;
  assign bus_s.clear_fault_i   = clear;

  ft_recovery_ctrl #(.RESET_CYCLES(1), .RECOVER_CYCLES(2), .TIMEOUT_CYCLES(16),
                     .MAX_RETRIES(2), .CNT_W(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_m)
  );

  ft_recovery_ctrl #(.RESET_CYCLES(1), .RECOVER_CYCLES(2), .TIMEOUT_CYCLES(16),
                     .MAX_RETRIES(2), .CNT_W(2)) dut_sat (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the outputs expected after the next falling edge, then step past it.
  task automatic tick(input est_t st);
    exp_t e;
    logic rc, rv, rg, f;
    logic [7:0] ecs;
    rc  = (st == E_RST);
    rv  = (st == E_REC);
    rg  = (st == E_REC) || (st == E_WAIT);
    f   = (st == E_FLT);
    ecs = (exp_ec > 8'd3) ? 8'd3 : exp_ec;
    e.vm  = {rc, rv, rg, f, exp_rt, exp_ec};
    e.vs  = {rc, rv, rg, f, exp_rt, ecs[1:0]};
    e.cyc = ncyc;
    ncyc++;
    sb.push_back(e);
    @(negedge clk_i);
    #3;
  endtask

  task automatic accept_error(input bit use_force);
    if (use_force) force_e = 1'b1;
    else           err     = 1'b1;
    if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
    exp_rt = 2'd0;
    tick(E_RST);
    err     = 1'b0;
    force_e = 1'b0;
  endtask

  task automatic episode(input int n_wait, input bit use_force, input bit hold_err);
    accept_error(use_force);
    done = 1'b1;                 // done outside WAIT_DONE must be ignored
    tick(E_REC);
    done = 1'b0;
    tick(E_REC);
    repeat (n_wait) tick(E_WAIT);
    done = 1'b1;
    tick(E_DONE);
    done = 1'b0;
    err  = hold_err;             // error in DONE ignored, accepted from IDLE next edge
    tick(E_IDLE);
  endtask

  always @(negedge clk_i) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk($sformatf("main_c%0d", mon_e.cyc),
          32'({bus_m.reset_cores_o, bus_m.recover_o, bus_m.recovering_o, bus_m.fault_o,
               bus_m.retry_count_o, bus_m.error_count_o}), 32'(mon_e.vm));
      chk($sformatf("sat_c%0d", mon_e.cyc),
          32'({bus_s.reset_cores_o, bus_s.recover_o, bus_s.recovering_o, bus_s.fault_o,
               bus_s.retry_count_o, bus_s.error_count_o}), 32'(mon_e.vs));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; en = 1'b1; err = 1'b0; force_e = 1'b0; done = 1'b0; clear = 1'b0;
    exp_rt = 2'd0; exp_ec = 8'd0;
    tick(E_IDLE); tick(E_IDLE);
    rst_i = 1'b0;
    tick(E_IDLE);

    // nominal episodes; the CNT_W=2 instance saturates at 3 after the third
    episode(3, 1'b0, 1'b0);
    episode(1, 1'b1, 1'b0);
    episode(5, 1'b0, 1'b1);
    episode(2, 1'b0, 1'b0);
    episode(4, 1'b1, 1'b0);

    // done on the 16th WAIT_DONE cycle beats the timeout
    episode(16, 1'b0, 1'b0);

    // timeouts: three attempts then permanent fault
    accept_error(1'b0);
    for (int a = 0; a < 3; a++) begin
      tick(E_REC); tick(E_REC);
      repeat (16) tick(E_WAIT);
      if (a < 2) begin
        exp_rt = exp_rt + 2'd1;
        tick(E_RST);
      end else begin
        tick(E_FLT);
      end
    end
    err = 1'b1; force_e = 1'b1;
    repeat (3) tick(E_FLT);
    err = 1'b0; force_e = 1'b0; done = 1'b1;
    tick(E_FLT);
    done = 1'b0; clear = 1'b1;
    tick(E_IDLE);
    clear = 1'b0;
    tick(E_IDLE);

    // freeze in IDLE, RECOVER and WAIT_DONE
    en = 1'b0; err = 1'b1;
    tick(E_IDLE); tick(E_IDLE);
    en = 1'b1;
    accept_error(1'b0);
    tick(E_REC);
    en = 1'b0; err = 1'b1;
    repeat (5) tick(E_REC);
    en = 1'b1; err = 1'b0;
    tick(E_REC);
    repeat (4) tick(E_WAIT);
    en = 1'b0;
    repeat (20) tick(E_WAIT);
    en = 1'b1;
    repeat (3) tick(E_WAIT);
    done = 1'b1;
    tick(E_DONE);
    done = 1'b0;
    tick(E_IDLE);

    // synchronous reset in WAIT_DONE with one retry used
    accept_error(1'b0);
    tick(E_REC); tick(E_REC);
    repeat (16) tick(E_WAIT);
    exp_rt = 2'd1;
    tick(E_RST);
    tick(E_REC); tick(E_REC);
    repeat (5) tick(E_WAIT);
    rst_i = 1'b1; err = 1'b1; done = 1'b1;
    exp_rt = 2'd0; exp_ec = 8'd0;
    tick(E_IDLE);
    rst_i = 1'b0; err = 1'b0; done = 1'b0;
    episode(3, 1'b1, 1'b0);

    @(negedge clk_i);
    #3;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
